// File: rtl/v_pkg.sv
// Shared vector-unit definitions: RVV major opcodes, vset* funct3, and the
// issue-queue entry/state types.
package v_pkg;

    localparam logic [6:0] OPC_RTYPE = 7'b1010111;  // OP-V (arith + vset*)
    localparam logic [6:0] OPC_LTYPE = 7'b0000111;  // LOAD-FP (vector loads)
    localparam logic [6:0] OPC_STYPE = 7'b0100111;  // STORE-FP (vector stores)
    localparam logic [2:0] OP_SET    = 3'b111;      // funct3 of vsetvl/vsetvli/vsetivli

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
    } v_iq_entry_t;

    typedef enum logic {
        IDLE     = 1'b0,
        CFG_WAIT = 1'b1
    } v_iq_state_t;

    // True for the three opcodes the vector decoder understands.
    function automatic logic is_vec_opcode(input logic [6:0] opc);
        logic res;
        case (opc)
            OPC_RTYPE: res = 1'b1;
            OPC_LTYPE: res = 1'b1;
            OPC_STYPE: res = 1'b1;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    // True for a vset* configuration instruction.
    function automatic logic is_vcfg(input logic [6:0] opc, input logic [2:0] funct3);
        return (opc == OPC_RTYPE) && (funct3 == OP_SET);
    endfunction

endpackage

// File: rtl/v_issue_queue.sv
// Issue queue between the scalar core's coprocessor port and the vector
// decoder. Circular buffer of {instr, x[rs1], x[rs2]} with a small FSM that
// holds dispatch after a vset* until the config unit reports completion.
module v_issue_queue
    import v_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    input  logic [31:0]   in_rs1_val,
    input  logic [31:0]   in_rs2_val,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_rs1_val,
    output logic [31:0]   out_rs2_val,
    input  logic          vcfg_done,
    output logic          cfg_wait,
    output logic          illegal_instr,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    v_iq_entry_t mem_q [DEPTH];
    v_iq_entry_t head_s;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    v_iq_state_t   state_q, state_d;
    logic          illegal_q, illegal_d;

    logic push_hs_s;   // handshake completes on the input side
    logic is_vec_s;    // offered word is a vector instruction
    logic push_s;      // entry is actually written
    logic pop_s;       // head entry leaves the queue
    logic head_cfg_s;  // head entry is a vset*

    assign head_s      = mem_q[rd_ptr_q];
    assign in_ready    = (count_q != FULL_CNT);
    assign out_valid   = (count_q != '0) && (state_q == IDLE);
    assign out_instr   = head_s.instr;
    assign out_rs1_val = head_s.rs1_val;
    assign out_rs2_val = head_s.rs2_val;
    assign cfg_wait    = (state_q == CFG_WAIT);
    assign illegal_instr = illegal_q;
    assign count       = count_q;

    assign push_hs_s  = in_valid && in_ready;
    assign is_vec_s   = is_vec_opcode(in_instr[6:0]);
    assign push_s     = push_hs_s && is_vec_s && !flush;
    assign pop_s      = out_valid && out_ready && !flush;
    assign head_cfg_s = is_vcfg(head_s.instr[6:0], head_s.instr[14:12]);

    // Next-state for pointers, occupancy, dispatch FSM and the drop flag.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        illegal_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = IDLE;
        end else begin
            illegal_d = push_hs_s && !is_vec_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            case (state_q)
                IDLE: begin
                    if (pop_s && head_cfg_s) begin
                        state_d = CFG_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                CFG_WAIT: begin
                    if (vcfg_done) begin
                        state_d = IDLE;
                    end else begin
                        state_d = CFG_WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state registers; reset acts as a flush and clears the drop flag.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= '{instr: in_instr, rs1_val: in_rs1_val, rs2_val: in_rs2_val};
        end
    end

endmodule

// File: tb/tb_v_issue_queue.sv
// Directed, table-driven bench for v_issue_queue (DEPTH = 4).
module tb_v_issue_queue;

    localparam logic [31:0] CFG    = 32'h0C05_72D7;  // vsetvli
    localparam logic [31:0] ADDI   = 32'h0000_0013;  // scalar addi
    localparam logic [31:0] RS1KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        nrst, flush, in_valid, in_ready, out_valid, out_ready;
    logic        vcfg_done, cfg_wait, illegal_instr;
    logic [31:0] in_instr, in_rs1_val, in_rs2_val;
    logic [31:0] out_instr, out_rs1_val, out_rs2_val;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    v_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .nrst(nrst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .vcfg_done(vcfg_done), .cfg_wait(cfg_wait),
        .illegal_instr(illegal_instr), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        nrst, fl, iv;
        logic [31:0] ins;
        logic        ordy, vd;
        logic [2:0]  cnt;
        logic        irdy, ov, cw, ill;
        logic [31:0] oi;
    } vec_t;

    vec_t vecs[$];

    // vadd.vv variants: only the vd field (bits 11:7) changes.
    function automatic logic [31:0] vw(input int n);
        return 32'h0200_8057 + (32'(n) << 7);
    endfunction

    function automatic void row(input logic rn, fl, iv, input logic [31:0] ins,
                                input logic ordy, vd, input logic [2:0] cnt,
                                input logic irdy, ov, cw, ill, input logic [31:0] oi);
        vec_t v;
        v.nrst = rn; v.fl = fl; v.iv = iv; v.ins = ins; v.ordy = ordy; v.vd = vd;
        v.cnt = cnt; v.irdy = irdy; v.ov = ov; v.cw = cw; v.ill = ill; v.oi = oi;
        vecs.push_back(v);
    endfunction

    task automatic chk(input int idx, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check just after the rising edge.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        nrst = v.nrst; flush = v.fl; in_valid = v.iv; in_instr = v.ins;
        in_rs1_val = v.ins ^ RS1KEY; in_rs2_val = ~v.ins;
        out_ready = v.ordy; vcfg_done = v.vd;
        @(posedge clk);
        #1;
        chk(idx, "count",         {29'b0, count},         {29'b0, v.cnt});
        chk(idx, "in_ready",      {31'b0, in_ready},      {31'b0, v.irdy});
        chk(idx, "out_valid",     {31'b0, out_valid},     {31'b0, v.ov});
        chk(idx, "cfg_wait",      {31'b0, cfg_wait},      {31'b0, v.cw});
        chk(idx, "illegal_instr", {31'b0, illegal_instr}, {31'b0, v.ill});
        if (v.ov) begin
            chk(idx, "out_instr",   out_instr,   v.oi);
            chk(idx, "out_rs1_val", out_rs1_val, v.oi ^ RS1KEY);
            chk(idx, "out_rs2_val", out_rs2_val, ~v.oi);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int b;
        int lat;
        vec_t v;
        nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
        in_rs1_val = 32'h0; in_rs2_val = 32'h0; out_ready = 1'b0; vcfg_done = 1'b0;

        // reset state
        row(1'b0,1'b0,1'b0,32'h0,1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        // fill to full, refuse extra push, drain in order; three rounds wrap the pointers
        for (int r = 0; r < 3; r++) begin
            b = r * 4;
            for (int k = 0; k < 4; k++)
                row(1'b1,1'b0,1'b1,vw(b+k),1'b0,1'b0, 3'(k+1),1'(k<3),1'b1,1'b0,1'b0,vw(b));
            row(1'b1,1'b0,1'b1,vw(30),1'b0,1'b0, 3'd4,1'b0,1'b1,1'b0,1'b0,vw(b));
            for (int j = 0; j < 4; j++)
                row(1'b1,1'b0,1'b0,32'h0,1'b1,1'b0, 3'(3-j),1'b1,1'(j<3),1'b0,1'b0,
                    (j < 3) ? vw(b+j+1) : 32'h0);
        end

        // simultaneous push/pop at count 2, refused push when full
        row(1'b1,1'b0,1'b1,vw(12),1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(12));
        row(1'b1,1'b0,1'b1,vw(13),1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,vw(12));
        row(1'b1,1'b0,1'b1,vw(14),1'b1,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,vw(13));
        row(1'b1,1'b0,1'b1,vw(15),1'b0,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,vw(13));
        row(1'b1,1'b0,1'b1,vw(16),1'b0,1'b0, 3'd4,1'b0,1'b1,1'b0,1'b0,vw(13));
        row(1'b1,1'b0,1'b1,vw(17),1'b1,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,vw(14));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,vw(15));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(16));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        // vconfig serialisation; push during wait; vcfg_done in IDLE ignored
        row(1'b1,1'b0,1'b1,CFG,   1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b1,vw(18),1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd1,1'b1,1'b0,1'b1,1'b0,32'h0);
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd1,1'b1,1'b0,1'b1,1'b0,32'h0);
        row(1'b1,1'b0,1'b1,vw(19),1'b1,1'b0, 3'd2,1'b1,1'b0,1'b1,1'b0,32'h0);
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b1, 3'd2,1'b1,1'b1,1'b0,1'b0,vw(18));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(19));
        row(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b1, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(19));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        // illegal drop: alone, and together with a pop
        row(1'b1,1'b0,1'b1,ADDI,  1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b1,32'h0);
        row(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);
        row(1'b1,1'b0,1'b1,vw(20),1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(20));
        row(1'b1,1'b0,1'b1,ADDI,  1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b1,32'h0);
        row(1'b1,1'b0,1'b0,32'h0, 1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        // flush with 3 entries in CFG_WAIT plus a push in the same cycle
        row(1'b1,1'b0,1'b1,CFG,   1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b1,vw(21),1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b1,vw(22),1'b0,1'b0, 3'd3,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd2,1'b1,1'b0,1'b1,1'b0,32'h0);
        row(1'b1,1'b0,1'b1,vw(23),1'b0,1'b0, 3'd3,1'b1,1'b0,1'b1,1'b0,32'h0);
        row(1'b1,1'b1,1'b1,vw(24),1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);
        row(1'b1,1'b1,1'b1,ADDI,  1'b0,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);
        row(1'b1,1'b0,1'b1,vw(25),1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(25));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        // reset mid-operation with 2 entries and a pending drop flag
        row(1'b1,1'b0,1'b1,vw(26),1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(26));
        row(1'b1,1'b0,1'b1,vw(27),1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,vw(26));
        row(1'b1,1'b0,1'b1,ADDI,  1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b1,vw(26));
        row(1'b0,1'b0,1'b1,vw(28),1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);
        row(1'b1,1'b0,1'b1,vw(29),1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,vw(29));
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd0,1'b1,1'b0,1'b0,1'b0,32'h0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

        // hand-written: config release latency with a bounded wait
        vecs.delete();
        row(1'b1,1'b0,1'b1,CFG,   1'b0,1'b0, 3'd1,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b1,vw(31),1'b0,1'b0, 3'd2,1'b1,1'b1,1'b0,1'b0,CFG);
        row(1'b1,1'b0,1'b0,32'h0, 1'b1,1'b0, 3'd1,1'b1,1'b0,1'b1,1'b0,32'h0);
        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], 1000 + i);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0; vcfg_done = 1'b0; in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk(1100 + i, "cfg_hold_out_valid", {31'b0, out_valid}, 32'd0);
        end
        @(negedge clk);
        vcfg_done = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && lat == 0) lat = c;
            @(negedge clk);
            vcfg_done = 1'b0;
        end
        chk(1110, "cfg_release_latency", 32'(lat), 32'd1);

        // hand-written: head stays stable while the decoder stalls
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            chk(1120 + i, "stall_out_instr", out_instr, vw(31));
        end
        v.nrst = 1'b1; v.fl = 1'b0; v.iv = 1'b0; v.ins = 32'h0; v.ordy = 1'b1; v.vd = 1'b0;
        v.cnt = 3'd0; v.irdy = 1'b1; v.ov = 1'b0; v.cw = 1'b0; v.ill = 1'b0; v.oi = 32'h0;
        apply(v, 1130);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/v_issue_queue.md
# v_issue_queue

Decoupling queue between the scalar core's coprocessor port and the vector decoder. Buffers vector instructions with their scalar operands (x[rs1], x[rs2]), presents the oldest entry to the decoder with a valid/ready handshake, and serialises vector-configuration instructions. Non-vector opcodes are dropped and flagged. Flush support covers scalar-side redirects.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- AW, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous, active-low reset
- flush  input  1  discard all entries and cancel the config wait
- in_valid  input  1  scalar core offers an instruction
- in_ready  output  1  queue can accept; equals count < DEPTH
- in_instr  input  32  raw instruction word
- in_rs1_val  input  32  scalar x[rs1] value
- in_rs2_val  input  32  scalar x[rs2] value (stride for strided load/store)
- out_valid  output  1  head entry available to decoder
- out_ready  input  1  decoder accepts head entry
- out_instr  output  32  head instruction (feeds decoder `instr`)
- out_rs1_val  output  32  head x[rs1]
- out_rs2_val  output  32  head x[rs2]
- vcfg_done  input  1  config unit has committed the new vl/vtype
- cfg_wait  output  1  dispatch is stalled behind an issued vconfig
- illegal_instr  output  1  one-cycle pulse: a non-vector opcode was accepted and dropped
- count  output  AW+1  current occupancy

## Operation

- **Push:** on `in_valid && in_ready` at a clk edge, with opcode in {OPC_RTYPE, OPC_LTYPE, OPC_STYPE}: write {instr, rs1, rs2} at wr_ptr, then increment wr_ptr (wraps mod DEPTH).
- **Non-vector opcode:** the handshake still completes, but nothing is written. `illegal_instr` = 1 in the next cycle.
- **Pop:** on `out_valid && out_ready`, increment rd_ptr (wraps mod DEPTH).
- **Output:** `out_*` are driven combinationally from the head entry. `out_valid` = (count != 0) && state == IDLE.
- **Vconfig (opcode OPC_RTYPE, funct3 OP_SET):**
  - Popping a vconfig moves the FSM IDLE -> CFG_WAIT.
  - In CFG_WAIT, `out_valid` = 0 and pushes continue normally.
  - `vcfg_done` = 1 in CFG_WAIT -> IDLE at the next edge. `vcfg_done` is ignored in IDLE.
- **count:**
  - +1 on push-only, -1 on pop-only.
  - Unchanged when a valid push and a pop occur together, or when a dropped push coincides with no pop.
- **Flush (highest priority):** next edge sets count, pointers and state to 0/IDLE. Any push or pop in the same cycle is ignored; `illegal_instr` is not raised for it.
- **Reset:** `nrst` = 0 at an edge behaves as flush and also clears `illegal_instr`.
  - After reset: `in_ready` = 1, `out_valid` = 0, `cfg_wait` = 0, `illegal_instr` = 0, `count` = 0.
  - Storage contents are don't-care and need no reset.

## Timing

- Push-to-out_valid latency: 1 cycle. There is no same-cycle bypass from input to output.
- Full queue (count == DEPTH): `in_ready` = 0 even if a pop occurs that cycle. There is no push-through when full.
- Empty queue with a simultaneous push: `out_valid` rises next cycle.
- `out_instr`/`out_rs*_val` stay stable while `out_valid && !out_ready`.
- The decoder must not see a post-vconfig instruction before the cycle after `vcfg_done`.
- `cfg_wait` = (state == CFG_WAIT), registered: it rises the cycle after the vconfig pop.
- Back-to-back pops sustain 1 entry/cycle in IDLE.

## Structure

- `v_pkg` (existing) supplies OPC_RTYPE, OPC_LTYPE, OPC_STYPE and OP_SET. Add:
  - typedef `v_iq_entry_t` (packed struct: instr, rs1_val, rs2_val)
  - typedef `v_iq_state_t` (IDLE, CFG_WAIT)
- Single module: storage array, pointers and FSM inline. No sub-module is warranted.

## Test plan

- **Fill and wrap:** reset, push 4 vadd.vv words (0x02008057 variants) with out_ready=0 -> `count`=4, `in_ready`=0. Drain 4 with out_ready=1 -> words emerge in order and `count` returns to 0. Repeat ×3 to exercise pointer wrap.
- **Simultaneous push/pop:** at `count`=2, push and pop in the same cycle -> `count` stays 2 and the head advances. At `count`=4, a push with a pop is refused (`in_ready`=0).
- **Vconfig serialisation:** queue {vsetvli 0x0C0572D7, vadd}.
  - After the vsetvli pop, `cfg_wait`=1 and `out_valid`=0 until `vcfg_done` is pulsed.
  - vadd appears the cycle after `vcfg_done`. A `vcfg_done` pulse in IDLE has no effect.
- **Illegal drop:** push 0x00000013 (addi) -> `in_ready` honoured, `count` unchanged, `illegal_instr`=1 for exactly 1 cycle.
- **Flush:** 3 entries in CFG_WAIT, then flush together with an in_valid push -> next cycle `count`=0, `cfg_wait`=0, `out_valid`=0, and the pushed word is absent.
- **Reset mid-operation:** `nrst`=0 for 1 cycle with 2 entries -> all outputs return to their reset values and a subsequent push/pop works normally.
